// File: rtl/tube_scan_driver.sv
// Multiplexed 7-segment scan driver with a CPU register file.
// Segments and digit enables are registered and active-low.
module tube_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 40000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  iFpgaClock,
    input  logic                  iCpuResetN,
    input  logic                  iDoTubeWrite,
    input  logic [2:0]            iTubeAddress,
    input  logic [15:0]           iTubeDataToWrite,
    output logic [NUM_DIGITS-1:0] oDigitalTubeNotEnable,
    output logic [7:0]            oDigitalTubeShape,
    output logic                  oFrameTick
);

    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0]   LAST_DIV   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]   BLANK_END  = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_FRAMES - 1);

    // CPU-visible registers
    logic [4*NUM_DIGITS-1:0] nib_q, nib_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic                    lzs_q, lzs_d;
    logic                    gen_q, gen_d;

    // Scan and blink timing
    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLINK_W-1:0]      bcnt_q, bcnt_d;
    logic                    phase_q, phase_d;
    logic                    slot_wrap;
    logic                    frame_tick;

    // Registered outputs
    logic [NUM_DIGITS-1:0]   ne_q, ne_d;
    logic [7:0]              shape_q, shape_d;

    // Visibility per digit
    logic [NUM_DIGITS-1:0]   nib_zero;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [NUM_DIGITS-1:0]   lz_supp;
    logic [NUM_DIGITS-1:0]   visible;
    logic [3:0]              cur_nib;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Register file write decode; nibble i lives at address i/4.
    always_comb begin
        nib_d   = nib_q;
        dp_d    = dp_q;
        en_d    = en_q;
        blink_d = blink_q;
        lzs_d   = lzs_q;
        gen_d   = gen_q;
        if (iDoTubeWrite) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (iTubeAddress == 3'(i / 4)) begin
                    nib_d[i*4 +: 4] = iTubeDataToWrite[(i % 4)*4 +: 4];
                end
            end
            case (iTubeAddress)
                3'd2: dp_d    = iTubeDataToWrite[NUM_DIGITS-1:0];
                3'd3: en_d    = iTubeDataToWrite[NUM_DIGITS-1:0];
                3'd4: blink_d = iTubeDataToWrite[NUM_DIGITS-1:0];
                3'd5: begin
                    lzs_d = iTubeDataToWrite[0];
                    gen_d = iTubeDataToWrite[1];
                end
                default: ;
            endcase
        end
    end

    assign slot_wrap  = (div_q == LAST_DIV);
    assign frame_tick = slot_wrap && (idx_q == LAST_IDX);
    assign oFrameTick = frame_tick;

    always_comb begin
        div_d   = slot_wrap ? '0 : div_q + 1'b1;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (slot_wrap) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        if (frame_tick) begin
            if (bcnt_q == LAST_BLINK) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    // zero_from[i]: nibbles i..top are all zero (leading-zero run).
    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = nib_zero[NUM_DIGITS-1];
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = nib_zero[i] & zero_from[i+1];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib_zero[gi] = (nib_q[gi*4 +: 4] == 4'd0);
            if (gi == 0) begin : g_first
                assign lz_supp[gi] = 1'b0;
            end else begin : g_rest
                assign lz_supp[gi] = lzs_q & zero_from[gi];
            end
            assign visible[gi] = gen_q & en_q[gi] & (~blink_q[gi] | phase_q) & ~lz_supp[gi];
        end
    endgenerate

    assign cur_nib = nib_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        ne_d    = '1;
        shape_d = 8'hFF;
        if ((div_q >= BLANK_END) && visible[idx_q]) begin
            ne_d    = ~(NUM_DIGITS'(1) << idx_q);
            shape_d = ~{dp_q[idx_q], seg7(cur_nib)};
        end
    end

    always_ff @(posedge iFpgaClock) begin
        if (!iCpuResetN) begin
            nib_q   <= '0;
            dp_q    <= '0;
            en_q    <= '1;
            blink_q <= '0;
            lzs_q   <= 1'b0;
            gen_q   <= 1'b1;
            div_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
            ne_q    <= '1;
            shape_q <= 8'hFF;
        end else begin
            nib_q   <= nib_d;
            dp_q    <= dp_d;
            en_q    <= en_d;
            blink_q <= blink_d;
            lzs_q   <= lzs_d;
            gen_q   <= gen_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            ne_q    <= ne_d;
            shape_q <= shape_d;
        end
    end

    assign oDigitalTubeNotEnable = ne_q;
    assign oDigitalTubeShape     = shape_q;

endmodule

// File: doc/tube_scan_driver.md
Name: tube_scan_driver

Overview:
- Parameterised multiplexed 7-segment display driver. Successor to the fixed 8-digit hex tube driver.
- Adds configurable digit count and scan rate, per-digit decimal point, digit enable and blink masks, leading-zero suppression, and anti-ghosting blank slots.
- Sits on the CPU MMIO path. The CPU writes 16-bit words to small register addresses, and the block drives the board's active-low digit enables and segments.
- Single clock domain.

Parameters:
- NUM_DIGITS, 8: digits driven. Legal values are 4 or 8.
- SCAN_DIV, 40000: clocks per digit slot. Minimum 2.
- BLANK_CYCLES, 2000: clocks at the start of each slot with all digits off. Must be less than SCAN_DIV.
- BLINK_FRAMES, 64: full scan frames per blink half-period. Minimum 1.

Ports:
- iFpgaClock, input, 1: sole clock.
- iCpuResetN, input, 1: reset. Synchronous, active-low.
- iDoTubeWrite, input, 1: write strobe, one cycle per write.
- iTubeAddress, input, 3: register select.
- iTubeDataToWrite, input, 16: write data.
- oDigitalTubeNotEnable, output, NUM_DIGITS: one-hot-low digit select.
- oDigitalTubeShape, output, 8: active-low segments. Bit 7 = dp, bits 6..0 = g..a.
- oFrameTick, output, 1: one-cycle pulse at the last clock of each frame.

Behaviour:
- Registers, written on a cycle with iDoTubeWrite=1 and iCpuResetN=1, take effect the next cycle:
  - Addr 0: hex nibbles for digits 3..0 (digit 0 = bits 3:0).
  - Addr 1: hex nibbles for digits 7..4. Ignored when NUM_DIGITS=4.
  - Addr 2: dp mask, bits NUM_DIGITS-1:0.
  - Addr 3: enable mask.
  - Addr 4: blink mask.
  - Addr 5: control. Bit 0 = leading-zero suppress (LZS), bit 1 = global enable (GEN).
  - Addr 6-7: ignored.
  - Unused upper data bits are ignored.
- Reset values when iCpuResetN=0 at a clock edge:
  - Data 0, dp 0, enable all ones, blink 0, LZS 0, GEN 1.
  - divCnt 0, digitIdx 0, blinkCnt 0, blinkPhase 1 (visible).
  - oDigitalTubeNotEnable all ones, oDigitalTubeShape 8'hFF, oFrameTick 0.
  - Reset overrides a simultaneous write.
- Scan counter:
  - divCnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digitIdx advances and wraps from NUM_DIGITS-1 to 0.
  - A frame is NUM_DIGITS slots.
  - oFrameTick=1 exactly in the cycle where divCnt=SCAN_DIV-1 and digitIdx=NUM_DIGITS-1.
- Blink counter:
  - blinkCnt increments per frame. At BLINK_FRAMES-1 it wraps to 0 and blinkPhase toggles.
- Digit visibility. Digit i is visible only if all of the following hold:
  - GEN=1.
  - enable[i]=1.
  - blink[i]=0, or blinkPhase=1.
  - Not LZ-suppressed. With LZS=1, digit i>0 is suppressed when nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed.
- Output timing:
  - Outputs are registered from the current divCnt, digitIdx and registers, so they lag by one clock.
  - When divCnt<BLANK_CYCLES, or the digit is not visible, the next outputs are NotEnable all ones and Shape 8'hFF.
  - Otherwise NotEnable = ~(1<<digitIdx) and Shape = ~{dp[digitIdx], seg(nibble)}.
- Segment decode, gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
- Write latency: a write in cycle t alters the outputs no earlier than edge t+2. Writing a digit's nibble mid-slot updates that digit within the same slot.
- Reset mid-slot: the next cycle shows blank outputs, and scanning restarts at digit 0, divCnt 0.
- Invariant: at most one NotEnable bit is low in any cycle.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2, NUM_DIGITS=8):
- Reset low for 3 cycles, then write addr0=16'h1234 and release. Expected:
  - Outputs read FF/FF during reset.
  - Digit 0 drives NotEnable=8'hFE, Shape=8'h99 ("4") for 3 clocks per slot with a 1-clock blank gap.
  - Digits 1..3 then show 3, 2, 1 (B0, A4, F9).
  - oFrameTick pulses every 32 clocks.
- Write addr1=0, addr0=16'h0050, ctrl=3. Expected:
  - Digits 7..2 stay blank (NotEnable=FF).
  - Digit 1 shows "5" (Shape 92).
  - Digit 0 shows "0" (C0).
- Write dp=8'h01, blink=8'h02. Expected:
  - Digit 0 Shape bit 7=0.
  - Digit 1 is visible for 2 frames and blank for 2 frames, alternating.
- Write ctrl=0 (GEN=0). Expected: all outputs FF from 2 clocks later, while oFrameTick continues.
- Write addr0 during digit 0's visible window. Expected: Shape changes within that slot, 2 clocks after the write.
- Assert iCpuResetN=0 mid-slot with a write on the same cycle. Expected: registers take their reset values, the write is discarded, and scanning restarts at digit 0.
